ctrl_pipe: RTL and testbench

CTRL_PIPE -- requirements
Module: ctrl_pipe

---
 rtl/ctrl_pipe.sv | 139 +++++++++++++
 tb/tb_ctrl_pipe.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: control-path pipeline for a 5-stage in-order core.
//   Carries decoded controls from ID through the ID/EX, EX/MEM and MEM/WB
//   registers. Also resolves the three control hazards: load-use stall,
//   taken branch and jump. Selects ALU operand forwarding sources.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   id_*                    decoder controls and register fields of the ID instruction
//   ex_zero                 ALU zero flag of the EX instruction
//   stall, flush_ifid       front-end hold / IF/ID squash (combinational)
//   pc_sel                  00 PC+4, 01 branch target, 10 jump target (combinational)
//   ex_*, mem_*, wb_*       stage controls (registered)
//   fwd_a, fwd_b            00 regfile, 10 EX/MEM, 01 MEM/WB (combinational)
module ctrl_pipe (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_jump,
  input  logic       id_regdst,
  input  logic       id_branch,
  input  logic       id_memr,
  input  logic       id_mem2r,
  input  logic       id_memw,
  input  logic       id_regw,
  input  logic       id_alusrc,
  input  logic [1:0] id_extop,
  input  logic [1:0] id_aluctrl,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic [4:0] id_rd,
  input  logic       ex_zero,
  output logic       stall,
  output logic       flush_ifid,
  output logic [1:0] pc_sel,
  output logic       ex_regdst,
  output logic       ex_alusrc,
  output logic       ex_branch,
  output logic [1:0] ex_aluctrl,
  output logic [1:0] ex_extop,
  output logic       mem_memr,
  output logic       mem_memw,
  output logic       wb_regw,
  output logic       wb_mem2r,
  output logic [4:0] wb_wreg,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  typedef struct packed {
    logic       regdst, alusrc, branch, memr, memw, regw, mem2r;
    logic [1:0] aluctrl, extop;
    logic [4:0] rs, rt, wreg;
  } idex_t;

  typedef struct packed {
    logic       memr, memw, regw, mem2r;
    logic [4:0] wreg;
  } exmem_t;

  typedef struct packed {
    logic       regw, mem2r;
    logic [4:0] wreg;
  } memwb_t;

  idex_t  idex, idex_d;
  exmem_t exmem;
  memwb_t memwb;

  logic uses_rt, load_use, taken, bubble;

  // Nearest producer wins; $0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] r,
                                         input exmem_t m, input memwb_t w);
    if (r != 5'd0 && m.regw && m.wreg == r)      return 2'b10;
    else if (r != 5'd0 && w.regw && w.wreg == r) return 2'b01;
    else                                         return 2'b00;
  endfunction

  always_comb begin
    uses_rt  = id_regdst | id_memw | id_branch;
    load_use = idex.memr && (idex.wreg != 5'd0) &&
               ((idex.wreg == id_rs) || (uses_rt && (idex.wreg == id_rt)));
    taken    = idex.branch & ex_zero;
    // Taken branch outranks the stall; a jump only redirects when nothing else does.
    stall      = rst_n & load_use & ~taken;
    flush_ifid = rst_n & (taken | (id_jump & ~load_use));
    if (!rst_n)        pc_sel = 2'b00;
    else if (taken)    pc_sel = 2'b01;
    else if (load_use) pc_sel = 2'b00;
    else if (id_jump)  pc_sel = 2'b10;
    else               pc_sel = 2'b00;
    fwd_a = fwd_sel(idex.rs, exmem, memwb);
    fwd_b = fwd_sel(idex.rt, exmem, memwb);
  end

  // Any redirect or stall turns the ID slot into a bubble. rs/rt are zeroed
  // too, so a bubble in EX can never request forwarding.
  always_comb begin
    bubble = taken | load_use | id_jump;
    idex_d = '0;
    if (!bubble) begin
      idex_d.regdst  = id_regdst;
      idex_d.alusrc  = id_alusrc;
      idex_d.branch  = id_branch;
      idex_d.memr    = id_memr;
      idex_d.memw    = id_memw;
      idex_d.regw    = id_regw;
      idex_d.mem2r   = id_mem2r;
      idex_d.aluctrl = id_aluctrl;
      idex_d.extop   = id_extop;
      idex_d.rs      = id_rs;
      idex_d.rt      = id_rt;
      idex_d.wreg    = id_regdst ? id_rd : id_rt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex  <= '0;
      exmem <= '0;
      memwb <= '0;
    end else begin
      idex  <= idex_d;
      exmem <= '{memr: idex.memr, memw: idex.memw, regw: idex.regw,
                 mem2r: idex.mem2r, wreg: idex.wreg};
      memwb <= '{regw: exmem.regw, mem2r: exmem.mem2r, wreg: exmem.wreg};
    end
  end

  assign ex_regdst  = idex.regdst;
  assign ex_alusrc  = idex.alusrc;
  assign ex_branch  = idex.branch;
  assign ex_aluctrl = idex.aluctrl;
  assign ex_extop   = idex.extop;
  assign mem_memr   = exmem.memr;
  assign mem_memw   = exmem.memw;
  assign wb_regw    = memwb.regw;
  assign wb_mem2r   = memwb.mem2r;
  assign wb_wreg    = memwb.wreg;

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: reference-model bench for ctrl_pipe. The model keeps the
// three instructions that most recently entered EX as a history list and
// derives every output from the hazard/forwarding rules.
module tb_ctrl_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       jump, regdst, branch, memr, mem2r, memw, regw, alusrc;
    logic [1:0] extop, aluctrl;
    logic [4:0] rs, rt, rd;
  } instr_t;

  typedef struct packed {
    logic       regdst, alusrc, branch, memr, memw, regw, mem2r;
    logic [1:0] aluctrl, extop;
    logic [4:0] rs, rt, wreg;
  } ent_t;

  instr_t cur;
  logic   cur_z;
  ent_t   st [3];   // 0 = in EX, 1 = in MEM, 2 = in WB
  int     checks = 0;
  int     errors = 0;

  logic       stall, flush_ifid, ex_regdst, ex_alusrc, ex_branch;
  logic       mem_memr, mem_memw, wb_regw, wb_mem2r;
  logic [1:0] pc_sel, ex_aluctrl, ex_extop, fwd_a, fwd_b;
  logic [4:0] wb_wreg;
  logic [23:0] allo;

  ctrl_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .id_jump(cur.jump), .id_regdst(cur.regdst), .id_branch(cur.branch),
    .id_memr(cur.memr), .id_mem2r(cur.mem2r), .id_memw(cur.memw),
    .id_regw(cur.regw), .id_alusrc(cur.alusrc), .id_extop(cur.extop),
    .id_aluctrl(cur.aluctrl), .id_rs(cur.rs), .id_rt(cur.rt), .id_rd(cur.rd),
    .ex_zero(cur_z),
    .stall(stall), .flush_ifid(flush_ifid), .pc_sel(pc_sel),
    .ex_regdst(ex_regdst), .ex_alusrc(ex_alusrc), .ex_branch(ex_branch),
    .ex_aluctrl(ex_aluctrl), .ex_extop(ex_extop),
    .mem_memr(mem_memr), .mem_memw(mem_memw),
    .wb_regw(wb_regw), .wb_mem2r(wb_mem2r), .wb_wreg(wb_wreg),
    .fwd_a(fwd_a), .fwd_b(fwd_b)
  );

  assign allo = {stall, flush_ifid, pc_sel, fwd_a, fwd_b, ex_regdst, ex_alusrc,
                 ex_branch, ex_aluctrl, ex_extop, mem_memr, mem_memw,
                 wb_regw, wb_mem2r, wb_wreg};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---- instruction builders ----
  function automatic instr_t r_type(input int rs, input int rt, input int rd);
    instr_t i = '0;
    i.regdst = 1'b1; i.regw = 1'b1; i.aluctrl = 2'b10;
    i.rs = 5'(rs); i.rt = 5'(rt); i.rd = 5'(rd);
    return i;
  endfunction
  function automatic instr_t lw(input int rs, input int rt);
    instr_t i = '0;
    i.memr = 1'b1; i.mem2r = 1'b1; i.regw = 1'b1; i.alusrc = 1'b1; i.extop = 2'b01;
    i.rs = 5'(rs); i.rt = 5'(rt);
    return i;
  endfunction
  function automatic instr_t sw(input int rs, input int rt);
    instr_t i = '0;
    i.memw = 1'b1; i.alusrc = 1'b1; i.extop = 2'b01;
    i.rs = 5'(rs); i.rt = 5'(rt);
    return i;
  endfunction
  function automatic instr_t beq(input int rs, input int rt);
    instr_t i = '0;
    i.branch = 1'b1; i.aluctrl = 2'b01;
    i.rs = 5'(rs); i.rt = 5'(rt);
    return i;
  endfunction
  function automatic instr_t jmp();
    instr_t i = '0;
    i.jump = 1'b1; i.regdst = 1'b1; i.aluctrl = 2'b11; i.rd = 5'd9;
    return i;
  endfunction

  // ---- reference model ----
  function automatic logic m_ld_use();
    logic reads_rt = cur.regdst | cur.memw | cur.branch;
    return st[0].memr && st[0].wreg != 5'd0 &&
           (st[0].wreg == cur.rs || (reads_rt && st[0].wreg == cur.rt));
  endfunction
  function automatic logic m_taken();
    return st[0].branch && cur_z;
  endfunction
  // Youngest older writer of r supplies it; MEM stage = 10, WB stage = 01.
  function automatic logic [1:0] m_fwd(input logic [4:0] r);
    for (int k = 1; k <= 2; k++)
      if (r != 5'd0 && st[k].regw && st[k].wreg == r)
        return (k == 1) ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  task automatic compare();
    logic lu, tk;
    logic [1:0] ps;
    lu = m_ld_use();
    tk = m_taken();
    ps = tk ? 2'b01 : (!lu && cur.jump) ? 2'b10 : 2'b00;
    chk("comb", {stall, flush_ifid, pc_sel, fwd_a, fwd_b},
        {lu && !tk, tk || (cur.jump && !lu), ps, m_fwd(st[0].rs), m_fwd(st[0].rt)});
    chk("stage", {ex_regdst, ex_alusrc, ex_branch, ex_aluctrl, ex_extop,
                  mem_memr, mem_memw, wb_regw, wb_mem2r, wb_wreg},
        {st[0].regdst, st[0].alusrc, st[0].branch, st[0].aluctrl, st[0].extop,
         st[1].memr, st[1].memw, st[2].regw, st[2].mem2r, st[2].wreg});
  endtask

  // Present an ID instruction, then compare mid-cycle.
  task automatic drive(input instr_t v, input logic z);
    cur = v; cur_z = z;
    #4;
    compare();
  endtask

  // Advance the model across one clock edge.
  task automatic tick();
    ent_t e = '0;
    logic squash = m_ld_use() || m_taken() || cur.jump;
    if (!squash) begin
      e.regdst = cur.regdst; e.alusrc = cur.alusrc; e.branch = cur.branch;
      e.memr = cur.memr; e.memw = cur.memw; e.regw = cur.regw; e.mem2r = cur.mem2r;
      e.aluctrl = cur.aluctrl; e.extop = cur.extop;
      e.rs = cur.rs; e.rt = cur.rt; e.wreg = cur.regdst ? cur.rd : cur.rt;
    end
    @(posedge clk);
    st[2] = st[1]; st[1] = st[0]; st[0] = e;
    #1;
  endtask

  initial begin
    instr_t r;
    for (int k = 0; k < 3; k++) st[k] = '0;
    rst_n = 1'b0;
    cur = jmp(); cur_z = 1'b1;
    #2;
    chk("reset_zero", allo, 24'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // lw $2,0($1) ; addu $3,$2,$4
    drive(lw(1, 2), 0); tick();
    drive(r_type(2, 4, 3), 0); chk("lu_stall1", stall, 1'b1); tick();
    drive(r_type(2, 4, 3), 0); chk("lu_stall2", stall, 1'b0); tick();
    drive('0, 0); chk("lu_fwd_a", fwd_a, 2'b01); chk("lu_ex_regdst", ex_regdst, 1'b1); tick();
    drive('0, 0); tick();

    // addu $5,$1,$2 ; subu $6,$5,$5
    drive(r_type(1, 2, 5), 0); tick();
    drive(r_type(5, 5, 6), 0); chk("alu_nostall", stall, 1'b0); tick();
    drive('0, 0); chk("alu_fwd", {fwd_a, fwd_b}, 4'b1010); tick();
    drive('0, 0); tick();

    // beq taken / not taken
    drive(beq(1, 2), 0); tick();
    drive(r_type(1, 2, 7), 1); chk("br_taken", {pc_sel, flush_ifid}, 3'b011); tick();
    drive('0, 0); chk("br_bubble", {ex_regdst, ex_aluctrl}, 3'b000); tick();
    drive(beq(1, 2), 0); tick();
    drive(r_type(1, 2, 7), 0); chk("br_not", {pc_sel, flush_ifid}, 3'b000); tick();
    drive('0, 0); chk("br_not_ex", {ex_regdst, ex_aluctrl}, 3'b110); tick();

    // jump
    drive(jmp(), 0); chk("jmp", {pc_sel, flush_ifid}, 3'b101); tick();
    drive('0, 0); chk("jmp_bubble", {ex_regdst, ex_alusrc, ex_branch, ex_aluctrl, ex_extop}, 7'h0); tick();

    // $0 never forwarded nor stalls
    drive(r_type(1, 2, 0), 0); tick();
    drive(r_type(0, 0, 6), 0); chk("r0_nostall", stall, 1'b0); tick();
    drive('0, 0); chk("r0_fwd", {fwd_a, fwd_b}, 4'b0000); tick();
    drive(lw(1, 0), 0); tick();
    drive(r_type(0, 0, 3), 0); chk("lw_r0_nostall", stall, 1'b0); tick();

    // randomized stream with dense register aliasing
    for (int n = 0; n < 400; n++) begin
      r = instr_t'({$urandom, $urandom});
      r.rs = 5'($urandom_range(0, 3));
      r.rt = 5'($urandom_range(0, 3));
      r.rd = 5'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) r.jump = 1'b0;
      drive(r, 1'($urandom));
      tick();
    end

    // async reset mid-stream, then a store walks to MEM
    drive(lw(1, 2), 0); tick();
    cur = jmp(); cur_z = 1'b1;
    #1 rst_n = 1'b0;
    for (int k = 0; k < 3; k++) st[k] = '0;
    #1 chk("rst_async", allo, 24'h0);
    #2 rst_n = 1'b1;
    cur = sw(1, 2); cur_z = 1'b0;
    #2 compare();
    tick();
    drive('0, 0); chk("sw_edge1", mem_memw, 1'b0); tick();
    drive('0, 0); chk("sw_edge2", mem_memw, 1'b1); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
